scan_controller: RTL and testbench
==================================

Name: scan_controller

Overview:
- Sequences one full 3D scan: captures one laser frame per turntable angle from the skeletonize stage, then steps the turntable and waits for it to settle.
- Sits between the video decoder timing (fvh_in) plus the skeletonize outputs (current_row, midpoint) and the downstream point-cloud writer.
- Buffers per-row samples {step, row, midpoint} in a small FIFO and drains them over a valid/ready handshake.

Parameters:
- NUM_STEPS, 200: turntable steps per scan (one frame captured per step).
- NUM_ROWS, 480: maximum rows accepted per frame; later line strobes in the same frame are ignored.
- STEP_PULSE_CYCLES, 1000: width of step_pulse high, in clk cycles.
- SETTLE_CYCLES, 2700000: delay from step pulse fall to re-arming capture.
- FIFO_DEPTH, 8: sample FIFO entries; power of two.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (reset==0 resets)
- start  in  1  one-cycle pulse; begins a scan when IDLE
- abort  in  1  one-cycle pulse; returns to IDLE from any state
- fvh_in  in  3  decoder {F,V,H} timing, same signal that feeds skeletonize
- current_row  in  9  from skeletonize
- midpoint  in  10  from skeletonize
- out_data  out  27  {step[7:0], row[8:0], midpoint[9:0]}
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accepts when out_valid&&out_ready
- step_pulse  out  1  turntable stepper pulse
- busy  out  1  state != IDLE
- scan_done  out  1  one-cycle pulse on the last step's completion
- overflow  out  1  sticky; sample dropped because FIFO full

Behaviour:
- Reset: state=IDLE; step counter=0; FIFO empty; all outputs 0; last_fvh=3'b000.
- Edge detection: last_fvh is registered every cycle.
  - new_frame = ~last_fvh[1] & fvh_in[1].
  - new_line = ~last_fvh[0] & fvh_in[0].
- Sample timing: skeletonize registers current_row/midpoint on the new_line edge. The controller therefore samples both one cycle after new_line (line_pending flag).
- FSM:
  - IDLE: start -> ARM; clears step counter and overflow.
  - ARM: wait for new_frame -> CAPTURE; clears row counter and first-line flag.
  - CAPTURE:
    - The first sample after new_frame is discarded, because it reflects blanking data.
    - Every later sample is pushed with the current step, while row counter < NUM_ROWS.
    - The next new_frame ends the frame -> STEP. A new_frame arriving on the same cycle as a pending sample: the sample is pushed first, then the transition happens.
  - STEP: step_pulse=1 for STEP_PULSE_CYCLES. Then the step counter increments:
    - If the counter reaches NUM_STEPS: -> DONE.
    - Otherwise: -> SETTLE.
  - SETTLE: count SETTLE_CYCLES with step_pulse=0 -> ARM.
  - DONE: scan_done=1 for one cycle -> IDLE.
- abort in any state -> IDLE next cycle:
  - step_pulse drops immediately; counters clear.
  - The FIFO is NOT flushed, so queued samples still drain.
- start outside IDLE is ignored.
- FIFO:
  - out_data is the head entry, first-word fall-through; out_valid=!empty.
  - Push and pop on the same cycle when full: both occur; count unchanged, no overflow.
  - Push when full without pop: sample dropped, overflow<=1 (sticky until next start or reset).
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count register is one bit wider than the pointers.
- Widths: the step field is the low 8 bits of the step counter (counter sized by $clog2(NUM_STEPS+1)). Delay counters are 32-bit.
- Reset asserted mid-operation: immediate return to the reset values, including the FIFO contents.

Optional Feature:
- Macro: SCAN_ZERO_SKIP_EN.
- Defined: in CAPTURE, a sample whose midpoint==0 (no laser found on the row) is not pushed and does not increment the row counter.
- Not defined: every valid sample is pushed, including midpoint 0.

Test Plan:
- Basic run: NUM_STEPS=2, NUM_ROWS=4, small delays, out_ready=1, start, 3 frames of 6 lines each, midpoints 100..105.
  - Expect samples rows 1..4 tagged step 0, then step 1.
  - Expect 2 step_pulses of STEP_PULSE_CYCLES, scan_done once, busy back to 0.
- Sample timing: new_line edge at cycle t, skeletonize midpoint changes at t+1.
  - Captured midpoint equals the value present at t+1, not the stale value.
- Backpressure: out_ready=0 with FIFO_DEPTH=8 over a 10-line frame.
  - Expect 8 entries held, overflow=1.
  - Releasing out_ready drains 8 entries in order, one per cycle.
- Simultaneous push/pop at full: fill the FIFO, then assert out_ready exactly on a sample cycle.
  - Count stays 8, overflow stays 0.
- Abort: abort during STEP.
  - step_pulse falls the next cycle, state IDLE, queued entries still drain.
  - A following start restarts from step 0.
- Reset mid-CAPTURE: reset=0 for 1 cycle.
  - All outputs 0, FIFO empty; no capture until start plus a new frame.

Source files
------------

// File: rtl/scan_controller.sv
// scan_controller: sequences one 3D scan. For every turntable angle it captures
// one laser frame of {step, row, midpoint} samples from the skeletonize stage,
// then pulses the stepper and waits for the turntable to settle before re-arming.
// Samples are buffered in a small first-word-fall-through FIFO.
//
// Ports:
//   clk, reset        system clock, asynchronous active-low reset
//   start, abort      one-cycle control pulses
//   fvh_in            decoder {F,V,H} timing
//   current_row       row index from skeletonize
//   midpoint          laser midpoint from skeletonize
//   out_data          FIFO head {step[7:0], row[8:0], midpoint[9:0]}
//   out_valid         FIFO non-empty
//   out_ready         downstream accept
//   step_pulse        stepper pulse (high while stepping)
//   busy              scan in progress
//   scan_done         one-cycle pulse after the last step
//   overflow          sticky, a sample was dropped on a full FIFO
//
// Optional feature: define SCAN_ZERO_SKIP_EN to drop samples whose midpoint is 0
// (no laser found on that row); such samples do not count against NUM_ROWS.
//
// STEP_PULSE_CYCLES and SETTLE_CYCLES must be >= 1; FIFO_DEPTH a power of two >= 2.
module scan_controller #(
  parameter int NUM_STEPS         = 200,
  parameter int NUM_ROWS          = 480,
  parameter int STEP_PULSE_CYCLES = 1000,
  parameter int SETTLE_CYCLES     = 2700000,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  fvh_in,
  input  logic [8:0]  current_row,
  input  logic [9:0]  midpoint,
  output logic [26:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        step_pulse,
  output logic        busy,
  output logic        scan_done,
  output logic        overflow
);

  localparam int SW  = $clog2(NUM_STEPS + 1);
  localparam int SWX = (SW > 8) ? SW : 8;
  localparam int RW  = $clog2(NUM_ROWS + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);

  localparam logic [SW-1:0] LAST_STEP   = SW'(NUM_STEPS - 1);
  localparam logic [RW-1:0] ROW_LIMIT   = RW'(NUM_ROWS);
  localparam logic [31:0]   PULSE_LAST  = 32'(STEP_PULSE_CYCLES - 1);
  localparam logic [31:0]   SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [PW:0]   FIFO_FULL   = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, ARM, CAPTURE, STEP, SETTLE, DONE} state_t;

  state_t         state, state_nxt;
  logic [2:0]     last_fvh;
  logic           line_pending;
  logic [SW-1:0]  step_cnt, step_nxt;
  logic [RW-1:0]  row_cnt, row_nxt;
  logic           first_seen, first_nxt;
  logic [31:0]    dly, dly_nxt;
  logic           ovf_clr;
  logic           push;
  logic           sample_ok;
  logic [SWX-1:0] step_ext;
  logic [26:0]    push_data;

  logic           new_frame, new_line;

  assign new_frame = ~last_fvh[1] & fvh_in[1];
  assign new_line  = ~last_fvh[0] & fvh_in[0];

`ifdef SCAN_ZERO_SKIP_EN
  assign sample_ok = (midpoint != 10'd0);
`else
  assign sample_ok = 1'b1;
`endif

  // skeletonize updates row/midpoint on the line edge, so the sample is taken
  // on the following cycle while line_pending is high.
  assign step_ext  = SWX'(step_cnt);
  assign push_data = {step_ext[7:0], current_row, midpoint};

  always_comb begin
    state_nxt = state;
    step_nxt  = step_cnt;
    row_nxt   = row_cnt;
    first_nxt = first_seen;
    dly_nxt   = dly;
    push      = 1'b0;
    ovf_clr   = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      step_nxt  = '0;
      row_nxt   = '0;
      first_nxt = 1'b0;
      dly_nxt   = '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_nxt = ARM;
          step_nxt  = '0;
          ovf_clr   = 1'b1;
        end
        ARM: if (new_frame) begin
          state_nxt = CAPTURE;
          row_nxt   = '0;
          first_nxt = 1'b0;
        end
        CAPTURE: begin
          // a pending sample is handled before a same-cycle frame edge ends capture
          if (line_pending) begin
            if (!first_seen)
              first_nxt = 1'b1;            // first line after the frame edge is blanking
            else if (sample_ok && row_cnt < ROW_LIMIT) begin
              push    = 1'b1;
              row_nxt = row_cnt + RW'(1);
            end
          end
          if (new_frame) begin
            state_nxt = STEP;
            dly_nxt   = '0;
          end
        end
        STEP: begin
          if (dly == PULSE_LAST) begin
            dly_nxt   = '0;
            step_nxt  = step_cnt + SW'(1);
            state_nxt = (step_cnt == LAST_STEP) ? DONE : SETTLE;
          end else begin
            dly_nxt = dly + 32'd1;
          end
        end
        SETTLE: begin
          if (dly == SETTLE_LAST) begin
            dly_nxt   = '0;
            state_nxt = ARM;
          end else begin
            dly_nxt = dly + 32'd1;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_fvh     <= 3'b000;
      line_pending <= 1'b0;
      step_cnt     <= '0;
      row_cnt      <= '0;
      first_seen   <= 1'b0;
      dly          <= '0;
    end else begin
      state        <= state_nxt;
      last_fvh     <= fvh_in;
      line_pending <= new_line;
      step_cnt     <= step_nxt;
      row_cnt      <= row_nxt;
      first_seen   <= first_nxt;
      dly          <= dly_nxt;
    end
  end

  assign busy       = (state != IDLE);
  assign step_pulse = (state == STEP);
  assign scan_done  = (state == DONE);

  // Sample FIFO: not touched by abort so queued samples still drain.
  logic [26:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, pop, push_ok;

  assign full      = (count == FIFO_FULL);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign push_ok   = push & (~full | pop);   // a pop frees the slot on the same cycle

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (ovf_clr)             overflow <= 1'b0;
      else if (push & ~push_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scan_controller.sv
// Bench for scan_controller: random midpoints per line, a queue model of the
// samples the scan should emit, and per-scenario tasks with inline checks.
module tb_scan_controller;

  localparam int NUM_STEPS         = 2;
  localparam int NUM_ROWS          = 10;
  localparam int STEP_PULSE_CYCLES = 4;
  localparam int SETTLE_CYCLES     = 5;
  localparam int FIFO_DEPTH        = 8;

  logic        clk = 1'b0;
  logic        reset, start, abort, out_ready;
  logic [2:0]  fvh_in;
  logic [8:0]  current_row;
  logic [9:0]  midpoint;
  logic [26:0] out_data;
  logic        out_valid, step_pulse, busy, scan_done, overflow;

  int checks = 0;
  int errors = 0;

  logic [26:0] exp_q[$];
  logic [26:0] got_q[$];
  bit          hold;     // out_ready held low: model tracks FIFO occupancy
  int          held;
  bit          exp_ovf;

  scan_controller #(
    .NUM_STEPS(NUM_STEPS), .NUM_ROWS(NUM_ROWS), .STEP_PULSE_CYCLES(STEP_PULSE_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .fvh_in(fvh_in),
    .current_row(current_row), .midpoint(midpoint), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .step_pulse(step_pulse),
    .busy(busy), .scan_done(scan_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Record every word the DUT hands over.
  always @(negedge clk)
    if (reset && out_valid && out_ready) got_q.push_back(out_data);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clear_model(input bit h);
    exp_q.delete(); got_q.delete();
    hold = h; held = 0; exp_ovf = 0;
  endtask

  // Frame edge followed by nlines lines; row/midpoint change one cycle after
  // each H edge (stale values during the edge cycle). ready_line pulses
  // out_ready on that line's sample cycle.
  task automatic send_frame(input int nlines, input bit cap, input int stepn, input int ready_line);
    int nrow; logic [8:0] r; logic [9:0] m; logic [7:0] st;
    nrow = 0; st = 8'(stepn);
    fvh_in = 3'b010; tick; fvh_in = 3'b000; tick;
    for (int i = 0; i < nlines; i++) begin
      r = 9'(i); m = 10'($urandom_range(1, 1023));
      fvh_in = 3'b001; current_row = ~r; midpoint = ~m; tick;
      fvh_in = 3'b000; current_row = r; midpoint = m;
      if (i == ready_line) begin out_ready = 1; if (held > 0) held--; end
      if (cap && i >= 1 && nrow < NUM_ROWS) begin
        nrow++;
        if (hold && held == FIFO_DEPTH) exp_ovf = 1;
        else begin exp_q.push_back({st, r, m}); if (hold) held++; end
      end
      tick;
      if (i == ready_line) out_ready = 0;
      tick;
    end
  endtask

  task automatic end_frame;
    fvh_in = 3'b010; tick; fvh_in = 3'b000;
  endtask

  // Full scan with out_ready high; checks pulse widths and scan_done.
  task automatic run_scan(input int nlines);
    int t, w;
    start = 1; tick; start = 0;
    for (int s = 0; s < NUM_STEPS; s++) begin
      send_frame(nlines, 1, s, -1);
      end_frame;
      t = 0; @(negedge clk);
      while (!step_pulse && t < 50) begin @(negedge clk); t++; end
      w = 0;
      while (step_pulse && w < 100) begin w++; @(negedge clk); end
      checks++;
      if (w !== STEP_PULSE_CYCLES) begin
        errors++; $display("FAIL step_width step %0d: got %0d exp %0d", s, w, STEP_PULSE_CYCLES);
      end
      checks++;
      if (scan_done !== (s == NUM_STEPS-1)) begin
        errors++; $display("FAIL scan_done step %0d: got %0b exp %0b", s, scan_done, s == NUM_STEPS-1);
      end
      if (s == NUM_STEPS-1) begin
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || scan_done !== 1'b0) begin
          errors++; $display("FAIL scan_end: busy %0b scan_done %0b exp 0 0", busy, scan_done);
        end
        tick;
      end else begin
        tick;
        if (s == 0) begin start = 1; tick; start = 0; end   // must be ignored
        repeat (SETTLE_CYCLES + 2) tick;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({out_valid, busy, step_pulse, scan_done, overflow, out_data} !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid %0b busy %0b step %0b done %0b ovf %0b data %h exp all 0",
               out_valid, busy, step_pulse, scan_done, overflow, out_data);
    end
    tick; reset = 1; tick;
  endtask

  task automatic test_basic;
    clear_model(0); out_ready = 1;
    run_scan(6);
    repeat (10) tick;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_count: got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_data[%0d]: got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_row_limit;
    clear_model(0); out_ready = 1;
    run_scan(NUM_ROWS + 4);
    repeat (10) tick;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL row_limit_count: got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL row_limit_data[%0d]: got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    clear_model(1); out_ready = 0;
    start = 1; tick; start = 0;
    send_frame(10, 1, 0, -1);
    abort = 1; tick; abort = 0;
    @(negedge clk);
    checks++;
    if (overflow !== exp_ovf || out_valid !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_state: ovf %0b valid %0b busy %0b exp %0b 1 0", overflow, out_valid, busy, exp_ovf);
    end
    tick; out_ready = 1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid[%0d]: got %0b exp 1", i, out_valid); end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %0b exp 0", out_valid); end
    tick;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_count: got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_data[%0d]: got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_push_pop_full;
    clear_model(1); out_ready = 0;
    start = 1; tick; start = 0;
    send_frame(10, 1, 0, 9);   // ninth sample lands on a full FIFO with a pop
    @(negedge clk);
    checks++;
    if (overflow !== exp_ovf || out_valid !== 1'b1) begin
      errors++; $display("FAIL pp_state: ovf %0b valid %0b exp %0b 1", overflow, out_valid, exp_ovf);
    end
    tick; abort = 1; tick; abort = 0; out_ready = 1;
    for (int i = 0; i < held; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL pp_drain_valid[%0d]: got %0b exp 1", i, out_valid); end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_empty: got %0b exp 0", out_valid); end
    tick;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL pp_count: got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL pp_data[%0d]: got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abort;
    clear_model(1); out_ready = 0;
    start = 1; tick; start = 0;
    send_frame(6, 1, 0, -1);
    end_frame;
    @(negedge clk);
    checks++;
    if (step_pulse !== 1'b1) begin errors++; $display("FAIL abort_pre_step: got %0b exp 1", step_pulse); end
    tick; abort = 1;
    tick; abort = 0;
    @(negedge clk);
    checks++;
    if (step_pulse !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL abort_state: step %0b busy %0b valid %0b exp 0 0 1", step_pulse, busy, out_valid);
    end
    tick; out_ready = 1; hold = 0;
    repeat (10) tick;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL abort_drain_count: got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL abort_drain[%0d]: got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    // restart must tag samples from step 0 again
    clear_model(0);
    run_scan(6);
    repeat (10) tick;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL restart_count: got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL restart_data[%0d]: got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_capture;
    clear_model(1); out_ready = 0;
    start = 1; tick; start = 0;
    send_frame(4, 1, 0, -1);
    reset = 0;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, step_pulse, scan_done, overflow, out_data} !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: valid %0b busy %0b step %0b done %0b ovf %0b data %h exp all 0",
               out_valid, busy, step_pulse, scan_done, overflow, out_data);
    end
    tick; reset = 1;
    clear_model(0);
    send_frame(6, 0, 0, -1);   // no start: nothing may be captured
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_idle: valid %0b busy %0b exp 0 0", out_valid, busy);
    end
    tick; start = 1; tick; start = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_restart: busy %0b valid %0b exp 1 0", busy, out_valid);
    end
    tick; abort = 1; tick; abort = 0; tick;
  endtask

  initial begin
    reset = 0; start = 0; abort = 0; out_ready = 0;
    fvh_in = 3'b000; current_row = '0; midpoint = '0;
    test_reset;
    test_basic;
    test_row_limit;
    test_backpressure;
    test_push_pop_full;
    test_abort;
    test_reset_mid_capture;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
